// File: rtl/switch_debouncer_pkg.sv
// Shared definitions for the switch debouncer: FSM state encoding,
// default cycle constants for a 50 MHz clock, and the level decode.
package switch_debouncer_pkg;

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,  // stable low
    S_RISE = 2'd1,  // candidate high, counting
    S_HIGH = 2'd2,  // stable high
    S_FALL = 2'd3   // candidate low, counting
  } state_e;

  // 10 ms debounce and 1 s long-press at 50 MHz
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_LONG_CYCLES     = 50000000;

  // Debounced level implied by a state: high once a rise has been accepted
  // and still high while a fall is only a candidate.
  function automatic logic level_of(input state_e s);
    logic lvl;
    case (s)
      S_LOW:   lvl = 1'b0;
      S_RISE:  lvl = 1'b0;
      S_HIGH:  lvl = 1'b1;
      S_FALL:  lvl = 1'b1;
      default: lvl = 1'b0;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/switch_debouncer_if.sv
// Signal bundle between a raw board switch and its debounced consumers.
// slave is the debouncer side; master is the board/consumer side.
interface switch_debouncer_if;

  logic switch;         // raw, asynchronous, bouncing input
  logic level;          // debounced level
  logic press;          // one-cycle pulse on level 0->1
  logic release_pulse;  // one-cycle pulse on level 1->0
  logic long_press;     // one-cycle pulse after a long continuous hold
  logic led;            // toggles on every press

  modport master (
    output switch,
    input  level, press, release_pulse, long_press, led
  );

  modport slave (
    input  switch,
    output level, press, release_pulse, long_press, led
  );

endinterface

// File: rtl/switch_debouncer_sync_2ff.sv
// Two-flop synchronizer (sync_2ff) for a single asynchronous board input.
// Both stages clear to 0 on reset; only the second stage is exported.
module switch_debouncer_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sync0_q, sync0_d;
  logic sync1_q, sync1_d;

  // Shift the raw input one stage per clock.
  always_comb begin
    sync0_d = d;
    sync1_d = sync0_q;
  end

  // Synchronizer stages, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
    end else begin
      sync0_q <= sync0_d;
      sync1_q <= sync1_d;
    end
  end

  assign q = sync1_q;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces a raw mechanical switch into a clean level plus press, release
// and long-press pulses, and a press-toggled LED. DEBOUNCE_CYCLES must be
// at least 2 and LONG_CYCLES must exceed DEBOUNCE_CYCLES.
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  switch_debouncer_if.slave  io
);

  localparam int CW = $clog2(LONG_CYCLES + 1);

  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(32'd1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LONG_MAX  = CW'(LONG_CYCLES);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);

  logic          sync_level;

  state_e        state_q, state_d;
  logic [CW-1:0] dcnt_q, dcnt_d;       // debounce counter
  logic [CW-1:0] hcnt_q, hcnt_d;       // hold counter
  logic          level_q, level_d;
  logic          level_dly_q, level_dly_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;
  logic          led_q, led_d;

  switch_debouncer_sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (io.switch),
    .q   (sync_level)
  );

  // Debounce FSM: a change is accepted only after DEBOUNCE_CYCLES
  // consecutive synchronized samples at the new polarity.
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      S_LOW: begin
        if (sync_level) begin
          state_d = S_RISE;
          dcnt_d  = CNT_ONE;
        end else begin
          dcnt_d  = CNT_ZERO;
        end
      end
      S_RISE: begin
        if (!sync_level) begin
          state_d = S_LOW;
          dcnt_d  = CNT_ZERO;
        end else if (dcnt_q == DEB_LAST) begin
          state_d = S_HIGH;
          dcnt_d  = CNT_ZERO;
        end else begin
          dcnt_d  = dcnt_q + CNT_ONE;
        end
      end
      S_HIGH: begin
        if (!sync_level) begin
          state_d = S_FALL;
          dcnt_d  = CNT_ONE;
        end else begin
          dcnt_d  = CNT_ZERO;
        end
      end
      S_FALL: begin
        if (sync_level) begin
          state_d = S_HIGH;
          dcnt_d  = CNT_ZERO;
        end else if (dcnt_q == DEB_LAST) begin
          state_d = S_LOW;
          dcnt_d  = CNT_ZERO;
        end else begin
          dcnt_d  = dcnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_LOW;
        dcnt_d  = CNT_ZERO;
      end
    endcase
  end

  // Level, edge pulses (one cycle after the level change) and LED toggle.
  always_comb begin
    level_d     = level_of(state_d);
    level_dly_d = level_q;
    press_d     = level_q & ~level_dly_q;
    release_d   = ~level_q & level_dly_q;
    led_d       = led_q ^ press_d;
  end

  // Hold counter: restarts on a fresh rise, keeps running through a
  // candidate fall so a bounce back continues the hold, saturates at
  // LONG_CYCLES and fires long_press on the step that reaches it.
  always_comb begin
    hcnt_d = hcnt_q;
    long_d = 1'b0;
    if (!level_d) begin
      hcnt_d = CNT_ZERO;
    end else if (!level_q) begin
      hcnt_d = CNT_ZERO;
    end else if (hcnt_q != LONG_MAX) begin
      hcnt_d = hcnt_q + CNT_ONE;
      long_d = (hcnt_q == LONG_LAST);
    end else begin
      hcnt_d = hcnt_q;
    end
  end

  // State, counters and output registers; reset aborts any count silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_LOW;
      dcnt_q      <= CNT_ZERO;
      hcnt_q      <= CNT_ZERO;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      led_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      hcnt_q      <= hcnt_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      led_q       <= led_d;
    end
  end

  assign io.level         = level_q;
  assign io.press         = press_q;
  assign io.release_pulse = release_q;
  assign io.long_press    = long_q;
  assign io.led           = led_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: a behavioural reference model pushes the
// expected output vector for every clock into a scoreboard queue, and a
// monitor pops and compares on the falling edge. Directed sequences add
// latency and boundary checks on top of randomized switch activity.
module tb_switch_debouncer;

  localparam int DEB  = 4;
  localparam int LONG = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  switch_debouncer_if sw_if ();

  switch_debouncer #(
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LONG)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (sw_if)
  );

  initial forever #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [4:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] dut_vec();
    return {sw_if.level, sw_if.press, sw_if.release_pulse, sw_if.long_press, sw_if.led};
  endfunction

  // ---------------- reference model ----------------
  // Level flips once DEB consecutive synchronized samples disagree with it;
  // the synchronized sample is the raw switch as seen two clocks earlier.
  bit m_level, m_press, m_rel, m_long, m_led, rise_last, fall_last, s_now;
  int m_run, m_hold;
  bit hist[$];

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_level = 1'b0; m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0; m_led = 1'b0;
      rise_last = 1'b0; fall_last = 1'b0; m_run = 0; m_hold = 0;
      hist.delete();
      exp_q.delete();
      exp_q.push_back(5'b00000);
    end else begin
      s_now = (hist.size() >= 2) ? hist[0] : 1'b0;
      hist.push_back(sw_if.switch);
      if (hist.size() > 2) void'(hist.pop_front());
      m_press = rise_last;
      m_rel   = fall_last;
      if (m_press) m_led = ~m_led;
      rise_last = 1'b0;
      fall_last = 1'b0;
      if (s_now != m_level) m_run++;
      else m_run = 0;
      if (m_run == DEB) begin
        m_level = ~m_level;
        m_run = 0;
        if (m_level) rise_last = 1'b1;
        else fall_last = 1'b1;
      end
      m_long = 1'b0;
      if (!m_level || rise_last) m_hold = 0;
      else begin
        m_hold++;
        if (m_hold == LONG) m_long = 1'b1;
      end
      exp_q.push_back({m_level, m_press, m_rel, m_long, m_led});
    end
  end

  // ---------------- monitor ----------------
  logic [4:0] mon_exp;
  initial forever begin
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_empty: no expected vector at %0t", $time);
    end else begin
      mon_exp = exp_q.pop_front();
      check("scoreboard {level,press,release,long,led}", {27'd0, dut_vec()}, {27'd0, mon_exp});
    end
  end

  // ---------------- stimulus ----------------
  int  rise_at, press_at, long_at, n_press, n_rel, n_long, quiet, seg_len;
  bit  led_expect;
  logic bounce_pat [7];

  task automatic observe(input int cycles);
    for (int i = 1; i <= cycles; i++) begin
      @(negedge clk);
      if (sw_if.level && rise_at == 0) rise_at = i;
      if (sw_if.press) begin n_press++; press_at = i; end
      if (sw_if.release_pulse) n_rel++;
      if (sw_if.long_press) begin n_long++; long_at = i; end
    end
  endtask

  task automatic clear_obs();
    rise_at = 0; press_at = 0; long_at = 0; n_press = 0; n_rel = 0; n_long = 0;
  endtask

  initial begin
    sw_if.switch = 1'b0;
    led_expect = 1'b0;
    bounce_pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    repeat (2) @(negedge clk);
    check("reset_state", {27'd0, dut_vec()}, 32'd0);
    rst = 1'b0;

    // quiet idle low
    quiet = 0;
    repeat (20) begin
      @(negedge clk);
      quiet += int'(sw_if.level) + int'(sw_if.press) + int'(sw_if.release_pulse) + int'(sw_if.long_press);
    end
    check("idle_quiet", quiet, 0);

    // clean step and long hold: first sampling edge is index 1
    clear_obs();
    sw_if.switch = 1'b1;
    observe(40);
    led_expect = ~led_expect;
    check("rise_latency", rise_at, 2 + DEB);
    check("press_latency", press_at, 3 + DEB);
    check("press_count", n_press, 1);
    check("long_latency", long_at, 2 + DEB + LONG);
    check("long_count", n_long, 1);
    check("led_after_press", sw_if.led, led_expect);

    // release: one release pulse, led unchanged
    clear_obs();
    sw_if.switch = 1'b0;
    observe(20);
    check("release_count", n_rel, 1);
    check("led_after_release", sw_if.led, led_expect);

    // bounce shorter than DEB
    clear_obs();
    for (int i = 0; i < 7; i++) begin
      sw_if.switch = bounce_pat[i];
      observe(1);
    end
    sw_if.switch = 1'b0;
    observe(15);
    check("bounce_no_level", rise_at, 0);
    check("bounce_no_press", n_press, 0);

    // pulse of DEB-1 cycles is rejected, exactly DEB cycles is accepted
    for (int w = DEB - 1; w <= DEB; w++) begin
      clear_obs();
      sw_if.switch = 1'b1;
      observe(w);
      sw_if.switch = 1'b0;
      observe(20);
      check("boundary_press", n_press, (w == DEB) ? 1 : 0);
      check("boundary_release", n_rel, (w == DEB) ? 1 : 0);
      if (w == DEB) led_expect = ~led_expect;
    end

    // two clean presses toggle led each time
    for (int p = 0; p < 2; p++) begin
      clear_obs();
      sw_if.switch = 1'b1;
      observe(10);
      sw_if.switch = 1'b0;
      observe(10);
      led_expect = ~led_expect;
      check("two_press_pulses", n_press + n_rel, 2);
      check("two_press_led", sw_if.led, led_expect);
    end

    // randomized activity, checked by the scoreboard
    for (int s = 0; s < 80; s++) begin
      sw_if.switch = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) seg_len = $urandom_range(DEB, LONG + 8);
      else seg_len = $urandom_range(1, DEB + 1);
      repeat (seg_len) @(negedge clk);
    end

    // asynchronous reset while stable high
    sw_if.switch = 1'b1;
    repeat (12) @(negedge clk);
    check("high_before_reset", sw_if.level, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset_outputs", {27'd0, dut_vec()}, 32'd0);
    @(negedge clk);
    sw_if.switch = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // reset while in S_RISE with count 3, switch held high through it
    clear_obs();
    sw_if.switch = 1'b1;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1 check("rise_reset_outputs", {27'd0, dut_vec()}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_obs();
    observe(20);
    check("post_reset_press_latency", press_at, 1 + 2 + DEB);
    check("post_reset_press_count", n_press, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
# switch_debouncer

Conditions a raw mechanical switch input into a clean, single-clock-domain level plus event pulses. It sits directly upstream of the switch-to-LED stage: the raw board switch goes in, and a debounced level, press/release/long-press pulses and a press-toggled `led` come out. It replaces the direct wiring of `switch` to `led` wherever bounce or metastability matters.

## Interface
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required before a change is accepted (10 ms at 50 MHz); must be ≥ 2.
- `LONG_CYCLES`, 50000000: cycles of debounced-high hold before `long_press` fires (1 s at 50 MHz); must be > `DEBOUNCE_CYCLES`.
- `clk` in 1: single system clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `switch` in 1: raw, asynchronous, bouncing switch input.
- `level` out 1: debounced switch level.
- `press` out 1: one-cycle pulse when `level` goes 0→1.
- `release` out 1: one-cycle pulse when `level` goes 1→0.
- `long_press` out 1: one-cycle pulse, at most once per press, after `LONG_CYCLES` of continuous high.
- `led` out 1: toggles on every `press`.

## Operation
- Synchronizer: two flops, `sync0` then `sync1`, both reset to 0. Only `sync1` is used downstream.
- FSM states (registered):
  - `S_LOW`: stable low.
  - `S_RISE`: candidate high, counting.
  - `S_HIGH`: stable high.
  - `S_FALL`: candidate low, counting.
  - Reset state is `S_LOW`.
- Transitions:
  - `S_LOW` → `S_RISE` when `sync1`=1. The debounce counter is set to 1.
  - `S_RISE`: if `sync1`=0, return to `S_LOW` and clear the counter. Otherwise increment the counter. When the counter equals `DEBOUNCE_CYCLES`−1 and `sync1`=1, go to `S_HIGH`.
  - `S_HIGH` and `S_FALL` mirror `S_LOW` and `S_RISE` with the polarity inverted.
- Counter width is `$clog2(LONG_CYCLES+1)`. The debounce counter and the hold counter are separate registers.
- `level` is 1 in `S_HIGH` and `S_FALL`, and 0 in `S_LOW` and `S_RISE`.
- `press` and `release` are registered. They assert for exactly one cycle, in the cycle after `level` changes.
- Hold counter:
  - Cleared on entry to `S_HIGH`.
  - Increments while `level`=1. It keeps counting during `S_FALL`, because a bounce back to `S_HIGH` continues the hold.
  - Saturates at `LONG_CYCLES`.
  - `long_press` pulses for one cycle when the counter first reaches `LONG_CYCLES`.
  - The counter clears when `level` returns to 0.
- `led` toggles in the same cycle that `press` asserts. `release` and `long_press` do not affect `led`.
- Boundary conditions:
  - Bounce shorter than `DEBOUNCE_CYCLES` produces no output change.
  - Bounce at exactly `DEBOUNCE_CYCLES` stable cycles is accepted.
  - A switch held high through reset is treated as a fresh press after reset release.

## Timing
- Reset values: `level`=0, `press`=0, `release`=0, `long_press`=0, `led`=0, all counters 0, state `S_LOW`.
- `rst` asserted mid-count aborts immediately with no pulse. Outputs return to their reset values asynchronously.
- Press latency, for a `switch` edge arriving before clock edge *k*:
  - `sync1` reflects it after edge *k*+1.
  - `level` rises after edge *k*+1+`DEBOUNCE_CYCLES`.
  - `press` and the `led` toggle occur after edge *k*+2+`DEBOUNCE_CYCLES`.
- Release latency is symmetric to press latency.
- `long_press` asserts `LONG_CYCLES` cycles after `level` rises.
- No handshake: consumers sample pulses every cycle.

## Structure
- Shared header `switch_pkg.vh` holds the state encodings (`S_LOW`=2'd0, `S_RISE`=2'd1, `S_HIGH`=2'd2, `S_FALL`=2'd3) and default cycle constants for 50 MHz.
- Sub-module `sync_2ff` contains the two-flop synchronizer, with async active-high reset to 0. It is reusable for other board inputs.
- The FSM, the counters and the output registers live in `switch_debouncer`.
- The downstream LED stage consumes `led` or `level` unchanged.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `LONG_CYCLES`=16.
- Reset with `switch`=0 → all outputs 0; hold 20 cycles → no pulses.
- Clean step 0→1 before edge 10 → `level`=1 after edge 15, `press` high only in cycle 16, `led`=1.
- Bounce pattern 1,1,0,1,1,1,0 after a low idle → `level` stays 0, no `press`.
- Hold high 30 cycles after `level` rises → exactly one `long_press`, 16 cycles after the rise. Then release → one `release` pulse, `led` unchanged.
- Two clean presses separated by releases → `led` goes 0→1→0, two `press` pulses and two `release` pulses.
- Assert `rst` while in `S_RISE` with counter=3 → outputs 0 at once, no `press`. After release with `switch` still 1 → `press` fires 6 cycles after the first post-reset edge.
